// File: rtl/ct_f_spsram_16384x128_ctrl_if.sv
// Request/response handshake plus SRAM wrapper pins for the 16384x128 SRAM front-end.
// "slave" is the controller view; "master" is the requester and SRAM-model view.
interface ct_f_spsram_16384x128_ctrl_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 128
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [STRB_W-1:0]     req_wstrb;
    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  init_done;
    logic [ADDR_WIDTH-1:0] A;
    logic                  CEN;
    logic                  GWEN;
    logic [DATA_WIDTH-1:0] WEN;
    logic [DATA_WIDTH-1:0] D;
    logic [DATA_WIDTH-1:0] Q;

    modport master (
        output req_vld, req_wr, req_addr, req_wdata, req_wstrb, rsp_rdy, Q,
        input  req_rdy, rsp_vld, rsp_data, init_done, A, CEN, GWEN, WEN, D
    );

    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, req_wstrb, rsp_rdy, Q,
        output req_rdy, rsp_vld, rsp_data, init_done, A, CEN, GWEN, WEN, D
    );
endinterface

// File: rtl/ct_f_spsram_16384x128_ctrl.sv
// Front-end for the 16384x128 single-port SRAM: zero-fill after reset, partial writes as
// read-modify-write, and in-order read data through a credit-protected response FIFO.
module ct_f_spsram_16384x128_ctrl #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 128,
    parameter int RSP_DEPTH  = 2,
    parameter int INIT_EN    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    ct_f_spsram_16384x128_ctrl_if.slave  bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_RMW   = 2'd2;
    localparam logic [1:0] ST_START = (INIT_EN != 0) ? ST_INIT : ST_RUN;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_d,
        input logic [DATA_WIDTH-1:0] new_d,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_d;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) res[8*i +: 8] = new_d[8*i +: 8];
        end
        return res;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    logic [1:0]            state_r;
    logic [ADDR_WIDTH-1:0] init_cnt_r;
    logic                  init_done_r;
    logic                  rd_inflight_r;
    logic [ADDR_WIDTH-1:0] rmw_addr_r;
    logic [DATA_WIDTH-1:0] rmw_wdata_r;
    logic [STRB_W-1:0]     rmw_wstrb_r;
    logic [DATA_WIDTH-1:0] fifo_mem_r [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      fifo_cnt_r;

    logic                  req_rdy_s, accept_s, rd_acc_s, wr_full_s, wr_part_s;
    logic                  push_s, pop_s, rsp_vld_s;
    logic                  cen_s, gwen_s;
    logic [ADDR_WIDTH-1:0] a_s;
    logic [DATA_WIDTH-1:0] wen_s, d_s;

    // A read issued last cycle still owns a FIFO slot, so it counts against the credits.
    assign req_rdy_s = !rst && (state_r == ST_RUN) &&
                       ((int'(fifo_cnt_r) + int'(rd_inflight_r)) < RSP_DEPTH);
    assign accept_s  = bus.req_vld && req_rdy_s;
    assign rd_acc_s  = accept_s && !bus.req_wr;
    assign wr_full_s = accept_s && bus.req_wr && (&bus.req_wstrb);
    assign wr_part_s = accept_s && bus.req_wr && (|bus.req_wstrb) && !(&bus.req_wstrb);
    assign rsp_vld_s = (fifo_cnt_r != {CNT_W{1'b0}});
    assign push_s    = rd_inflight_r;
    assign pop_s     = rsp_vld_s && bus.rsp_rdy;

    assign bus.req_rdy   = req_rdy_s;
    assign bus.rsp_vld   = rsp_vld_s;
    assign bus.rsp_data  = fifo_mem_r[rd_ptr_r];
    assign bus.init_done = init_done_r;
    assign bus.A         = a_s;
    assign bus.CEN       = cen_s;
    assign bus.GWEN      = gwen_s;
    assign bus.WEN       = wen_s;
    assign bus.D         = d_s;

    // SRAM pin decode; reset forces idle so a pending RMW merge is never written.
    always_comb begin
        cen_s  = 1'b1;
        gwen_s = 1'b1;
        wen_s  = {DATA_WIDTH{1'b1}};
        a_s    = {ADDR_WIDTH{1'b0}};
        d_s    = {DATA_WIDTH{1'b0}};
        if (rst) begin
            cen_s = 1'b1;
        end else begin
            case (state_r)
                ST_INIT: begin
                    cen_s  = 1'b0;
                    gwen_s = 1'b0;
                    wen_s  = {DATA_WIDTH{1'b0}};
                    a_s    = init_cnt_r;
                end
                ST_RUN: begin
                    if (rd_acc_s || wr_part_s) begin
                        cen_s = 1'b0;
                        a_s   = bus.req_addr;
                    end else if (wr_full_s) begin
                        cen_s  = 1'b0;
                        gwen_s = 1'b0;
                        wen_s  = {DATA_WIDTH{1'b0}};
                        a_s    = bus.req_addr;
                        d_s    = bus.req_wdata;
                    end else begin
                        cen_s = 1'b1;
                    end
                end
                ST_RMW: begin
                    cen_s  = 1'b0;
                    gwen_s = 1'b0;
                    wen_s  = {DATA_WIDTH{1'b0}};
                    a_s    = rmw_addr_r;
                    d_s    = merge_bytes(bus.Q, rmw_wdata_r, rmw_wstrb_r);
                end
                default: cen_s = 1'b1;
            endcase
        end
    end

    // Control state, init sweep counter and RMW capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_START;
            init_cnt_r    <= {ADDR_WIDTH{1'b0}};
            init_done_r   <= (INIT_EN != 0) ? 1'b0 : 1'b1;
            rd_inflight_r <= 1'b0;
            rmw_addr_r    <= {ADDR_WIDTH{1'b0}};
            rmw_wdata_r   <= {DATA_WIDTH{1'b0}};
            rmw_wstrb_r   <= {STRB_W{1'b0}};
        end else begin
            rd_inflight_r <= rd_acc_s;
            case (state_r)
                ST_INIT: begin
                    init_cnt_r <= init_cnt_r + ADDR_WIDTH'(1);
                    if (init_cnt_r == {ADDR_WIDTH{1'b1}}) begin
                        state_r     <= ST_RUN;
                        init_done_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (wr_part_s) begin
                        state_r     <= ST_RMW;
                        rmw_addr_r  <= bus.req_addr;
                        rmw_wdata_r <= bus.req_wdata;
                        rmw_wstrb_r <= bus.req_wstrb;
                    end
                end
                ST_RMW:  state_r <= ST_RUN;
                default: state_r <= ST_START;
            endcase
        end
    end

    // Response FIFO: SRAM Q is captured the cycle after a request read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {CNT_W{1'b0}};
            for (int i = 0; i < RSP_DEPTH; i++) fifo_mem_r[i] <= {DATA_WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= bus.Q;
                wr_ptr_r             <= ptr_next(wr_ptr_r);
            end
            if (pop_s) rd_ptr_r <= ptr_next(rd_ptr_r);
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    ct_f_spsram_16384x128_ctrl_chk #(.CNT_W(CNT_W), .RSP_DEPTH(RSP_DEPTH)) u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .cnt  (fifo_cnt_r)
    );
endmodule

// Protocol checker: the credit scheme must never push into a full response FIFO.
module ct_f_spsram_16384x128_ctrl_chk #(
    parameter int CNT_W     = 2,
    parameter int RSP_DEPTH = 2
) (
    input logic             clk,
    input logic             rst,
    input logic             push,
    input logic [CNT_W-1:0] cnt
);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (int'(cnt) == RSP_DEPTH)));
endmodule

// File: tb/tb_ct_f_spsram_16384x128_ctrl.sv
// Bench for ct_f_spsram_16384x128_ctrl: directed vector table, hand sequences for credits
// and reset-during-RMW, and random traffic checked against a word-level memory model.
module tb_ct_f_spsram_16384x128_ctrl;
    localparam int AW    = 14;
    localparam int DW    = 128;
    localparam int DEPTH = 16384;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic scramble = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    ct_f_spsram_16384x128_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ct_f_spsram_16384x128_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(2), .INIT_EN(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // SRAM wrapper model: Q is registered and only updates on read cycles.
    logic [DW-1:0] sram [0:DEPTH-1];
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= {4{32'hDEADBEEF}} ^ DW'(i);
        end else if (!bus.CEN) begin
            if (!bus.GWEN) sram[bus.A] <= (sram[bus.A] & bus.WEN) | (bus.D & ~bus.WEN);
            else           bus.Q <= sram[bus.A];
        end
    end

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [15:0]   wstrb;
        logic          exp_cen;
        logic          exp_gwen;
        logic          exp_rmw;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t          vecs [15];
    logic [DW-1:0] model_mem [int];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_w,
                                                 input logic [DW-1:0] new_w,
                                                 input logic [15:0]   strb);
        logic [DW-1:0] mask = '0;
        for (int b = 0; b < 16; b++) mask[8*b +: 8] = {8{strb[b]}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    function automatic logic [DW-1:0] model_read(input int a);
        return model_mem.exists(a) ? model_mem[a] : {DW{1'b0}};
    endfunction

    task automatic init_sweep(input string tag);
        int errs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check({tag, "_first_addr"}, DW'(bus.A), DW'(0));
                check({tag, "_rsp_empty"}, DW'(bus.rsp_vld), DW'(0));
            end
            if (bus.CEN !== 1'b0 || bus.GWEN !== 1'b0 || bus.WEN !== {DW{1'b0}} ||
                bus.D !== {DW{1'b0}} || bus.A !== AW'(i) || bus.req_rdy !== 1'b0 ||
                bus.init_done !== 1'b0 || bus.rsp_vld !== 1'b0) errs++;
        end
        check({tag, "_sweep_errors"}, DW'(errs), DW'(0));
        @(negedge clk);
        check({tag, "_init_done"}, DW'(bus.init_done), DW'(1));
        check({tag, "_idle_cen"}, DW'(bus.CEN), DW'(1));
        check({tag, "_run_rdy"}, DW'(bus.req_rdy), DW'(1));
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        bit got = 1'b0;
        bus.req_vld   = 1'b1;
        bus.req_wr    = v.wr;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        bus.req_wstrb = v.wstrb;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (bus.req_rdy) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check({tag, "_accept"}, DW'(got), DW'(1));
        if (got) begin
            check({tag, "_cen"}, DW'(bus.CEN), DW'(v.exp_cen));
            check({tag, "_gwen"}, DW'(bus.GWEN), DW'(v.exp_gwen));
            if (!v.exp_cen) check({tag, "_addr"}, DW'(bus.A), DW'(v.addr));
            if (!v.exp_cen && !v.exp_gwen) begin
                check({tag, "_wen"}, bus.WEN, {DW{1'b0}});
                check({tag, "_d"}, bus.D, v.wdata);
            end
            @(posedge clk); #1;
            bus.req_vld = 1'b0;
            @(negedge clk);
            if (v.exp_rmw) begin
                check({tag, "_rmw_rdy_low"}, DW'(bus.req_rdy), DW'(0));
                check({tag, "_rmw_cen"}, DW'(bus.CEN), DW'(0));
                check({tag, "_rmw_gwen"}, DW'(bus.GWEN), DW'(0));
                check({tag, "_rmw_wen"}, bus.WEN, {DW{1'b0}});
                check({tag, "_rmw_addr"}, DW'(bus.A), DW'(v.addr));
                @(negedge clk);
                check({tag, "_rmw_rdy_back"}, DW'(bus.req_rdy), DW'(1));
            end else if (!v.wr) begin
                check({tag, "_rsp_early"}, DW'(bus.rsp_vld), DW'(0));
                @(negedge clk);
                check({tag, "_rsp_vld"}, DW'(bus.rsp_vld), DW'(1));
                check({tag, "_rsp_data"}, bus.rsp_data, v.exp_rdata);
            end else begin
                check({tag, "_no_rsp"}, DW'(bus.rsp_vld), DW'(0));
                check({tag, "_idle_after"}, DW'(bus.CEN), DW'(1));
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic acc;
        int   n_acc;
        logic [DW-1:0] pat;
        vec_t post;

        pat = 128'h0123456789ABCDEF_FEDCBA9876543210;
        vecs[0]  = '{1'b1, 14'h0123, {16{8'hA5}}, 16'hFFFF, 1'b0, 1'b0, 1'b0, {DW{1'b0}}};
        vecs[1]  = '{1'b0, 14'h0123, {DW{1'b0}},  16'h0000, 1'b0, 1'b1, 1'b0, {16{8'hA5}}};
        vecs[2]  = '{1'b1, 14'h0010, {DW{1'b1}},  16'hFFFF, 1'b0, 1'b0, 1'b0, {DW{1'b0}}};
        vecs[3]  = '{1'b1, 14'h0010, {DW{1'b0}},  16'h0001, 1'b0, 1'b1, 1'b1, {DW{1'b0}}};
        vecs[4]  = '{1'b0, 14'h0010, {DW{1'b0}},  16'h0000, 1'b0, 1'b1, 1'b0, {{120{1'b1}}, 8'h00}};
        vecs[5]  = '{1'b1, 14'h0200, {DW{1'b1}},  16'h0000, 1'b1, 1'b1, 1'b0, {DW{1'b0}}};
        vecs[6]  = '{1'b0, 14'h0200, {DW{1'b0}},  16'h0000, 1'b0, 1'b1, 1'b0, {DW{1'b0}}};
        vecs[7]  = '{1'b0, 14'h3FFF, {DW{1'b0}},  16'h0000, 1'b0, 1'b1, 1'b0, {DW{1'b0}}};
        vecs[8]  = '{1'b1, 14'h0005, pat,         16'hF0F0, 1'b0, 1'b1, 1'b1, {DW{1'b0}}};
        vecs[9]  = '{1'b0, 14'h0005, {DW{1'b0}},  16'h0000, 1'b0, 1'b1, 1'b0,
                     128'h01234567_00000000_FEDCBA98_00000000};
        vecs[10] = '{1'b1, 14'h0001, {16{8'h11}}, 16'hFFFF, 1'b0, 1'b0, 1'b0, {DW{1'b0}}};
        vecs[11] = '{1'b1, 14'h0002, {16{8'h22}}, 16'hFFFF, 1'b0, 1'b0, 1'b0, {DW{1'b0}}};
        vecs[12] = '{1'b1, 14'h0003, {16{8'h33}}, 16'hFFFF, 1'b0, 1'b0, 1'b0, {DW{1'b0}}};
        vecs[13] = '{1'b1, 14'h0010, {8'hC3, 120'h0}, 16'h8000, 1'b0, 1'b1, 1'b1, {DW{1'b0}}};
        vecs[14] = '{1'b0, 14'h0010, {DW{1'b0}},  16'h0000, 1'b0, 1'b1, 1'b0,
                     {8'hC3, {112{1'b1}}, 8'h00}};

        bus.req_vld   = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.rsp_rdy   = 1'b1;

        repeat (3) @(posedge clk);
        #1 scramble = 1'b0;
        @(negedge clk);
        check("rst_req_rdy", DW'(bus.req_rdy), DW'(0));
        check("rst_rsp_vld", DW'(bus.rsp_vld), DW'(0));
        check("rst_init_done", DW'(bus.init_done), DW'(0));
        check("rst_cen", DW'(bus.CEN), DW'(1));
        check("rst_gwen", DW'(bus.GWEN), DW'(1));
        check("rst_wen", bus.WEN, {DW{1'b1}});
        check("rst_a", DW'(bus.A), DW'(0));
        check("rst_d", bus.D, {DW{1'b0}});
        @(posedge clk); #1;
        rst = 1'b0;
        init_sweep("t1");

        for (int i = 0; i < 15; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // Credit limit: with the consumer stalled only two reads may be outstanding.
        bus.rsp_rdy = 1'b0;
        n_acc = 0;
        got_q.delete();
        bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 14'h0001;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 6) begin
                check("t4_accepts_before_stall", DW'(n_acc), DW'(2));
                check("t4_rdy_low", DW'(bus.req_rdy), DW'(0));
            end
            if (bus.req_vld && bus.req_rdy) n_acc++;
            if (bus.rsp_vld && bus.rsp_rdy) got_q.push_back(bus.rsp_data);
            @(posedge clk); #1;
            if (n_acc >= 3) bus.req_vld = 1'b0;
            else            bus.req_addr = AW'(n_acc + 1);
            if (c == 6) bus.rsp_rdy = 1'b1;
        end
        check("t4_rsp_count", DW'(got_q.size()), DW'(3));
        for (int i = 0; i < 3; i++)
            check($sformatf("t4_rsp%0d", i), (i < got_q.size()) ? got_q[i] : {DW{1'b0}},
                  {16{8'(8'h11 * (i + 1))}});

        // Random traffic against a word-level model on an area the directed vectors leave zero.
        bus.req_vld = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            if (bus.rsp_vld && bus.rsp_rdy) begin
                check("rnd_rsp_expected", DW'(exp_q.size() != 0), DW'(1));
                if (exp_q.size() != 0) check("rnd_rsp_data", bus.rsp_data, exp_q.pop_front());
            end
            acc = bus.req_vld && bus.req_rdy;
            if (acc) begin
                if (!bus.req_wr) exp_q.push_back(model_read(int'(bus.req_addr)));
                else model_mem[int'(bus.req_addr)] =
                    apply_strb(model_read(int'(bus.req_addr)), bus.req_wdata, bus.req_wstrb);
            end
            @(posedge clk); #1;
            if (c >= 2400) begin
                if (acc) bus.req_vld = 1'b0;
            end else if (acc || !bus.req_vld) begin
                bus.req_vld   = ($urandom_range(0, 3) != 0);
                bus.req_wr    = 1'($urandom_range(0, 1));
                bus.req_addr  = 14'h1000 + 14'($urandom_range(0, 7));
                bus.req_wdata = {$urandom, $urandom, $urandom, $urandom};
                case ($urandom_range(0, 3))
                    0:       bus.req_wstrb = 16'h0000;
                    1:       bus.req_wstrb = 16'hFFFF;
                    default: bus.req_wstrb = 16'($urandom_range(1, 16'hFFFE));
                endcase
            end
            bus.rsp_rdy = (c >= 2400) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
        check("rnd_all_returned", DW'(exp_q.size()), DW'(0));

        // Reset during the RMW merge cycle with a response still buffered.
        bus.rsp_rdy = 1'b0;
        bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 14'h0123;
        @(negedge clk);
        check("t5_rd_rdy", DW'(bus.req_rdy), DW'(1));
        @(posedge clk); #1;
        bus.req_wr = 1'b1; bus.req_addr = 14'h0124;
        bus.req_wdata = {16{8'h5A}}; bus.req_wstrb = 16'h00FF;
        @(negedge clk);
        check("t5_wr_rdy", DW'(bus.req_rdy), DW'(1));
        @(posedge clk); #1;
        bus.req_vld = 1'b0;
        @(negedge clk);
        check("t5_rmw_rdy", DW'(bus.req_rdy), DW'(0));
        check("t5_rmw_cen", DW'(bus.CEN), DW'(0));
        check("t5_fifo_busy", DW'(bus.rsp_vld), DW'(1));
        rst = 1'b1;
        #1;
        check("t5_rst_cen", DW'(bus.CEN), DW'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rsp_rdy = 1'b1;
        init_sweep("t5");

        post = '{1'b0, 14'h0123, {DW{1'b0}}, 16'h0000, 1'b0, 1'b1, 1'b0, {DW{1'b0}}};
        run_vec("post_0123", post);
        post.addr = 14'h0124;
        run_vec("post_0124", post);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
